// File: rtl/seq_pattern_gen_if.sv
// Handshake and serial-output bundle for seq_pattern_gen.
// The master side requests transfers and the slave side (the generator) drives the serial stream.
interface seq_pattern_gen_if #(
  parameter int REP_W = 4
) ();
  logic             start_i;
  logic [REP_W-1:0] reps_i;
  logic             abort_i;
  logic             out_o;
  logic             valid_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, reps_i, abort_i,
    input  out_o, valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, reps_i, abort_i,
    output out_o, valid_o, busy_o, done_o
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts PATTERN out MSB first, repeated a latched number of
// times with GAP idle cycles between repetitions; every output is registered.
module seq_pattern_gen #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b11001,
  parameter int               REP_W   = 4,
  parameter int               GAP     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_pattern_gen_if.slave bus
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX  = IDX_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    GAPPING = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [REP_W-1:0] reps_left_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             out_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [IDX_W-1:0] bit_idx_d;

  // Index of the bit that goes out after the one currently on the line.
  assign bit_idx_d = bit_idx_q - IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      reps_left_q <= '0;
      gap_cnt_q   <= '0;
      out_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_i && !bus.abort_i) begin
            state_q     <= SEND;
            bit_idx_q   <= MSB_IDX;
            reps_left_q <= (bus.reps_i == '0) ? REP_W'(1) : bus.reps_i;
            out_q       <= PATTERN[PAT_W-1];
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        SEND: begin
          if (bus.abort_i) begin
            state_q <= IDLE;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (bit_idx_q != '0) begin
            bit_idx_q <= bit_idx_d;
            out_q     <= PATTERN[bit_idx_d];
          end else if (reps_left_q > REP_W'(1)) begin
            // Repetitions are counted down when the next one is committed to.
            if (GAP > 0) begin
              state_q   <= GAPPING;
              gap_cnt_q <= GAP_LAST;
              out_q     <= 1'b0;
              valid_q   <= 1'b0;
            end else begin
              reps_left_q <= reps_left_q - REP_W'(1);
              bit_idx_q   <= MSB_IDX;
              out_q       <= PATTERN[PAT_W-1];
            end
          end else begin
            state_q <= IDLE;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        GAPPING: begin
          if (bus.abort_i) begin
            state_q <= IDLE;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (gap_cnt_q == '0) begin
            state_q     <= SEND;
            reps_left_q <= reps_left_q - REP_W'(1);
            bit_idx_q   <= MSB_IDX;
            out_q       <= PATTERN[PAT_W-1];
            valid_q     <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          out_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_o   = out_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: one instance with a 2-cycle gap and one back-to-back instance share
// the same stimulus and are checked every cycle against a timeline model of each transfer.
module tb_seq_pattern_gen;

  localparam logic [4:0] PAT = 5'b11001;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  seq_pattern_gen_if #(.REP_W(4)) if_a ();
  seq_pattern_gen_if #(.REP_W(4)) if_b ();

  seq_pattern_gen #(.PAT_W(5), .PATTERN(5'b11001), .REP_W(4), .GAP(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  seq_pattern_gen #(.PAT_W(5), .PATTERN(5'b11001), .REP_W(4), .GAP(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a transfer is a timeline t = cycles since the first bit appeared.
  bit m_act [2];
  int m_t   [2];
  int m_r   [2];

  function automatic int gap_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Expected {out, valid, busy, done} for the cycle currently visible.
  function automatic logic [3:0] exp_tup(input int d);
    int g;
    int total;
    int pos;
    logic [4:0] p;
    g = gap_of(d);
    p = PAT;
    if (!m_act[d]) return 4'b0000;
    total = 5 * m_r[d] + g * (m_r[d] - 1);
    if (m_t[d] < total) begin
      pos = m_t[d] % (5 + g);
      if (pos < 5) return {p[4 - pos], 3'b110};
      return 4'b0010;
    end
    if (m_t[d] == total) return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [7:0] exp8();
    return {exp_tup(0), exp_tup(1)};
  endfunction

  function automatic logic [7:0] obs8();
    return {if_a.out_o, if_a.valid_o, if_a.busy_o, if_a.done_o,
            if_b.out_o, if_b.valid_o, if_b.busy_o, if_b.done_o};
  endfunction

  task automatic model_edge(input int d, input logic st, input logic [3:0] rp, input logic ab);
    logic [3:0] tup;
    tup = exp_tup(d);
    if (tup[1]) begin
      if (ab) m_act[d] = 1'b0;
      else    m_t[d]   = m_t[d] + 1;
    end else if (st && !ab) begin
      m_act[d] = 1'b1;
      m_t[d]   = 0;
      m_r[d]   = (rp == 4'd0) ? 1 : int'(rp);
    end else begin
      m_act[d] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0;
      m_t[d]   = 0;
      m_r[d]   = 1;
    end
  endtask

  // Drive one cycle of inputs to both instances, clock once, advance the model, sample at +1.
  task automatic step(input logic st, input logic [3:0] rp, input logic ab);
    if_a.start_i = st; if_a.reps_i = rp; if_a.abort_i = ab;
    if_b.start_i = st; if_b.reps_i = rp; if_b.abort_i = ab;
    @(posedge clk);
    model_edge(0, st, rp, ab);
    model_edge(1, st, rp, ab);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 200 && (m_act[0] || m_act[1]); i++) step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if_a.start_i = i[0]; if_b.start_i = i[0];
      @(posedge clk); #1;
      checks++;
      if (obs8() !== 8'h00) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%b want=%b", i, obs8(), 8'h00);
      end
    end
    if_a.start_i = 1'b0; if_b.start_i = 1'b0;
    model_reset();
    rst_n = 1'b1;
    $display("test_reset: %0d cycles held in reset", 6);
  endtask

  task automatic test_single_shot();
    logic [4:0] ser = '0;
    int busy_n = 0;
    int done_idx = -1;
    for (int i = 0; i < 8; i++) begin
      step(i == 0, 4'd1, 1'b0);
      checks++;
      if (obs8() !== exp8()) begin
        errors++;
        $display("FAIL single_shot cyc=%0d got=%b want=%b", i, obs8(), exp8());
      end
      if (if_a.valid_o) ser = {ser[3:0], if_a.out_o};
      if (if_a.busy_o) busy_n++;
      if (if_a.done_o && done_idx < 0) done_idx = i;
    end
    checks++;
    if (ser !== PAT || busy_n != 5 || done_idx != 5) begin
      errors++;
      $display("FAIL single_shot_summary got bits=%b busy=%0d done_at=%0d want bits=%b busy=5 done_at=5",
               ser, busy_n, done_idx, PAT);
    end
    $display("test_single_shot: bits=%b busy=%0d done_at=%0d", ser, busy_n, done_idx);
  endtask

  task automatic test_repeat_gap();
    int busy_a = 0, valid_a = 0, done_a = 0, busy_b = 0;
    for (int i = 0; i < 16; i++) begin
      step(i == 0, 4'd2, 1'b0);
      checks++;
      if (obs8() !== exp8()) begin
        errors++;
        $display("FAIL repeat_gap cyc=%0d got=%b want=%b", i, obs8(), exp8());
      end
      busy_a += int'(if_a.busy_o); valid_a += int'(if_a.valid_o);
      done_a += int'(if_a.done_o); busy_b += int'(if_b.busy_o);
    end
    checks++;
    if (busy_a != 12 || valid_a != 10 || done_a != 1 || busy_b != 10) begin
      errors++;
      $display("FAIL repeat_gap_counts got busy=%0d valid=%0d done=%0d busy_b=%0d want 12 10 1 10",
               busy_a, valid_a, done_a, busy_b);
    end
    $display("test_repeat_gap: busy=%0d valid=%0d done=%0d", busy_a, valid_a, done_a);
  endtask

  task automatic test_back_to_back();
    logic [14:0] stream = '0;
    logic [14:0] want_stream;
    int nbits = 0, fires = 0, done_b = 0;
    want_stream = 15'b110011100111001;
    for (int i = 0; i < 22; i++) begin
      step(i == 0, 4'd3, 1'b0);
      checks++;
      if (obs8() !== exp8()) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", i, obs8(), exp8());
      end
      if (if_b.valid_o) begin
        stream = {stream[13:0], if_b.out_o};
        nbits++;
      end
      done_b += int'(if_b.done_o);
    end
    for (int i = 0; i <= 10; i++) if (stream[i +: 5] == PAT) fires++;
    checks++;
    if (stream !== want_stream || nbits != 15 || fires != 3 || done_b != 1) begin
      errors++;
      $display("FAIL back_to_back_stream got=%b n=%0d fires=%0d done=%0d want=%b n=15 fires=3 done=1",
               stream, nbits, fires, done_b, want_stream);
    end
    $display("test_back_to_back: stream=%b fires=%0d", stream, fires);
  endtask

  task automatic test_reps_zero_hold();
    logic valid_hist [20];
    int done_idx = -1;
    for (int i = 0; i < 20; i++) begin
      step(i < 10, 4'd0, 1'b0);
      checks++;
      if (obs8() !== exp8()) begin
        errors++;
        $display("FAIL reps_zero_hold cyc=%0d got=%b want=%b", i, obs8(), exp8());
      end
      valid_hist[i] = if_a.valid_o;
      if (if_a.done_o && done_idx < 0) done_idx = i;
    end
    checks++;
    if (done_idx != 5 || valid_hist[6] !== 1'b1 || valid_hist[4] !== 1'b1) begin
      errors++;
      $display("FAIL reps_zero_restart got done_at=%0d valid_after=%b want done_at=5 valid_after=1",
               done_idx, valid_hist[6]);
    end
    settle();
    $display("test_reps_zero_hold: first done at cycle %0d", done_idx);
  endtask

  task automatic test_abort();
    int done_n = 0;
    step(1'b1, 4'd2, 1'b1);
    checks++;
    if (obs8() !== 8'h00) begin
      errors++;
      $display("FAIL abort_start_idle got=%b want=%b", obs8(), 8'h00);
    end
    for (int i = 0; i < 12; i++) begin
      step(i == 0, 4'd2, i == 3);
      checks++;
      if (obs8() !== exp8()) begin
        errors++;
        $display("FAIL abort cyc=%0d got=%b want=%b", i, obs8(), exp8());
      end
      done_n += int'(if_a.done_o) + int'(if_b.done_o);
    end
    checks++;
    if (done_n != 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d want=0", done_n);
    end
    $display("test_abort: done pulses after abort=%0d", done_n);
  endtask

  task automatic test_async_reset_gap();
    for (int i = 0; i < 6; i++) begin
      step(i == 0, 4'd2, 1'b0);
      checks++;
      if (obs8() !== exp8()) begin
        errors++;
        $display("FAIL async_pre cyc=%0d got=%b want=%b", i, obs8(), exp8());
      end
    end
    if_a.start_i = 1'b0; if_b.start_i = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs8() !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got=%b want=%b", obs8(), 8'h00);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd0, 1'b0);
      checks++;
      if (obs8() !== exp8()) begin
        errors++;
        $display("FAIL async_post cyc=%0d got=%b want=%b", i, obs8(), exp8());
      end
    end
    $display("test_async_reset_gap: outputs cleared mid-gap");
  endtask

  task automatic test_max_reps();
    int busy_a = 0, busy_b = 0;
    int want_a, want_b;
    want_a = 5 * 15 + 2 * 14;
    want_b = 5 * 15;
    for (int i = 0; i < 110; i++) begin
      step(i == 0, 4'd15, 1'b0);
      checks++;
      if (obs8() !== exp8()) begin
        errors++;
        $display("FAIL max_reps cyc=%0d got=%b want=%b", i, obs8(), exp8());
      end
      busy_a += int'(if_a.busy_o);
      busy_b += int'(if_b.busy_o);
    end
    checks++;
    if (busy_a != want_a || busy_b != want_b) begin
      errors++;
      $display("FAIL max_reps_busy got a=%0d b=%0d want a=%0d b=%0d", busy_a, busy_b, want_a, want_b);
    end
    $display("test_max_reps: busy a=%0d b=%0d", busy_a, busy_b);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 6)), $urandom_range(0, 39) == 0);
      checks++;
      if (obs8() !== exp8()) begin
        errors++;
        bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", i, obs8(), exp8());
      end
    end
    settle();
    $display("test_random: 800 cycles, %0d differing", bad);
  endtask

  initial begin
    rst_n = 1'b0;
    if_a.start_i = 1'b0; if_a.reps_i = '0; if_a.abort_i = 1'b0;
    if_b.start_i = 1'b0; if_b.reps_i = '0; if_b.abort_i = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_single_shot();
    settle();
    test_repeat_gap();
    settle();
    test_back_to_back();
    settle();
    test_reps_zero_hold();
    test_abort();
    settle();
    test_async_reset_gap();
    test_max_reps();
    settle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
